// File: rtl/sc_run_controller.sv
// Run sequencer for the single-cycle CPU: holds the CPU in reset, watches the PC for halt/timeout/fault, then freezes it.
// Optional PC history output (last four RUN-cycle PCs) is enabled by defining SC_RUN_PCHIST_EN.
module sc_run_controller #(
    parameter int RESET_CYCLES = 4,
    parameter int HALT_REPEAT  = 3,
    parameter int MAX_CYCLES   = 100000,
    parameter int IMEM_BYTES   = 4096
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [31:0]  cpu_pc,
    output logic         cpu_rst_n,
    output logic         busy,
    output logic         done,
    output logic [1:0]   status,
    output logic [31:0]  final_pc,
    output logic [31:0]  run_cycles
`ifdef SC_RUN_PCHIST_EN
    ,
    output logic [127:0] pc_hist
`endif
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_HOLD = 2'd1;
    localparam logic [1:0] ST_RUN  = 2'd2;
    localparam logic [1:0] ST_DONE = 2'd3;

    localparam logic [1:0] STAT_NONE    = 2'b00;
    localparam logic [1:0] STAT_HALT    = 2'b01;
    localparam logic [1:0] STAT_TIMEOUT = 2'b10;
    localparam logic [1:0] STAT_FAULT   = 2'b11;

    localparam logic [31:0] HOLD_LAST   = 32'(RESET_CYCLES - 1);
    localparam logic [31:0] HALT_LIMIT  = 32'(HALT_REPEAT);
    localparam logic [31:0] MAX_LIMIT   = 32'(MAX_CYCLES);
    localparam logic [31:0] IMEM_LIMIT  = 32'(IMEM_BYTES);

    logic [1:0]  state_reg,      state_next;
    logic [31:0] hold_cnt_reg,   hold_cnt_next;
    logic        cpu_rst_n_reg,  cpu_rst_n_next;
    logic [1:0]  status_reg,     status_next;
    logic [31:0] final_pc_reg,   final_pc_next;
    logic [31:0] run_cycles_reg, run_cycles_next;
    logic [31:0] prev_pc_reg,    prev_pc_next;
    logic        prev_valid_reg, prev_valid_next;
    logic [31:0] same_cnt_reg,   same_cnt_next;

    logic [31:0] run_cycles_inc;
    logic        pc_repeat;
    logic        pc_fault;
    logic        hit_halt;
    logic        hit_timeout;
    logic        start_accept;

    // Saturating increment: the run length must never wrap back to a small value.
    assign run_cycles_inc = (run_cycles_reg == 32'hFFFF_FFFF) ? run_cycles_reg
                                                               : run_cycles_reg + 32'd1;
    assign pc_repeat    = prev_valid_reg && (cpu_pc == prev_pc_reg);
    assign pc_fault     = (cpu_pc[1:0] != 2'b00) || (cpu_pc >= IMEM_LIMIT);
    assign hit_halt     = pc_repeat && ((same_cnt_reg + 32'd1) >= HALT_LIMIT);
    assign hit_timeout  = run_cycles_inc >= MAX_LIMIT;
    assign start_accept = start && ((state_reg == ST_IDLE) || (state_reg == ST_DONE));

    always_comb begin
        state_next      = state_reg;
        hold_cnt_next   = hold_cnt_reg;
        cpu_rst_n_next  = cpu_rst_n_reg;
        status_next     = status_reg;
        final_pc_next   = final_pc_reg;
        run_cycles_next = run_cycles_reg;
        prev_pc_next    = prev_pc_reg;
        prev_valid_next = prev_valid_reg;
        same_cnt_next   = same_cnt_reg;

        case (state_reg)
            ST_IDLE, ST_DONE: begin
                if (start_accept) begin
                    state_next      = ST_HOLD;
                    hold_cnt_next   = 32'd0;
                    cpu_rst_n_next  = 1'b0;
                    status_next     = STAT_NONE;
                    run_cycles_next = 32'd0;
                    prev_pc_next    = 32'd0;
                    prev_valid_next = 1'b0;
                    same_cnt_next   = 32'd0;
                end
            end
            ST_HOLD: begin
                if (hold_cnt_reg >= HOLD_LAST) begin
                    state_next     = ST_RUN;
                    cpu_rst_n_next = 1'b1;
                end else begin
                    hold_cnt_next = hold_cnt_reg + 32'd1;
                end
            end
            ST_RUN: begin
                run_cycles_next = run_cycles_inc;
                prev_pc_next    = cpu_pc;
                prev_valid_next = 1'b1;
                same_cnt_next   = pc_repeat ? same_cnt_reg + 32'd1 : 32'd0;
                // Fault outranks halt, which outranks timeout, when they land on the same cycle.
                if (pc_fault || hit_halt || hit_timeout) begin
                    state_next     = ST_DONE;
                    cpu_rst_n_next = 1'b0;
                    final_pc_next  = cpu_pc;
                    if (pc_fault) begin
                        status_next = STAT_FAULT;
                    end else if (hit_halt) begin
                        status_next = STAT_HALT;
                    end else begin
                        status_next = STAT_TIMEOUT;
                    end
                end
            end
            default: begin
                state_next     = ST_IDLE;
                cpu_rst_n_next = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg      <= ST_IDLE;
            hold_cnt_reg   <= 32'd0;
            cpu_rst_n_reg  <= 1'b0;
            status_reg     <= STAT_NONE;
            final_pc_reg   <= 32'd0;
            run_cycles_reg <= 32'd0;
            prev_pc_reg    <= 32'd0;
            prev_valid_reg <= 1'b0;
            same_cnt_reg   <= 32'd0;
        end else begin
            state_reg      <= state_next;
            hold_cnt_reg   <= hold_cnt_next;
            cpu_rst_n_reg  <= cpu_rst_n_next;
            status_reg     <= status_next;
            final_pc_reg   <= final_pc_next;
            run_cycles_reg <= run_cycles_next;
            prev_pc_reg    <= prev_pc_next;
            prev_valid_reg <= prev_valid_next;
            same_cnt_reg   <= same_cnt_next;
        end
    end

`ifdef SC_RUN_PCHIST_EN
    logic [127:0] pc_hist_reg;

    // Newest PC enters at [31:0]; the window freezes once the run ends.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pc_hist_reg <= '0;
        end else if (start_accept) begin
            pc_hist_reg <= '0;
        end else if (state_reg == ST_RUN) begin
            pc_hist_reg <= {pc_hist_reg[95:0], cpu_pc};
        end
    end

    assign pc_hist = pc_hist_reg;
`endif

    assign cpu_rst_n  = cpu_rst_n_reg;
    assign busy       = (state_reg == ST_HOLD) || (state_reg == ST_RUN);
    assign done       = (state_reg == ST_DONE);
    assign status     = status_reg;
    assign final_pc   = final_pc_reg;
    assign run_cycles = run_cycles_reg;

endmodule

// File: tb/tb_sc_run_controller.sv
// Directed bench for sc_run_controller: reset, hold length, halt, timeout, fault, priorities, abort and re-run.
module tb_sc_run_controller;

    localparam int RESET_CYCLES = 4;
    localparam int HALT_REPEAT  = 3;
    localparam int MAX_CYCLES   = 10;
    localparam int IMEM_BYTES   = 4096;

    logic        clk    = 1'b0;
    logic        rst    = 1'b0;
    logic        start  = 1'b0;
    logic [31:0] cpu_pc = 32'd0;
    logic        cpu_rst_n;
    logic        busy;
    logic        done;
    logic [1:0]  status;
    logic [31:0] final_pc;
    logic [31:0] run_cycles;
`ifdef SC_RUN_PCHIST_EN
    logic [127:0] pc_hist;
`endif

    int          vectors     = 0;
    int          miscompares = 0;
    int          start_at    = -1;
    logic [31:0] pc_vec [0:15];

    sc_run_controller #(
        .RESET_CYCLES (RESET_CYCLES),
        .HALT_REPEAT  (HALT_REPEAT),
        .MAX_CYCLES   (MAX_CYCLES),
        .IMEM_BYTES   (IMEM_BYTES)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .cpu_pc     (cpu_pc),
        .cpu_rst_n  (cpu_rst_n),
        .busy       (busy),
        .done       (done),
        .status     (status),
        .final_pc   (final_pc),
        .run_cycles (run_cycles)
`ifdef SC_RUN_PCHIST_EN
        ,
        .pc_hist    (pc_hist)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_ramp(input int len, input logic [31:0] base);
        for (int i = 0; i < len; i++) begin
            pc_vec[i] = base + 32'(4 * i);
        end
    endtask

    // Pulse start, check the cleared outputs, then count the cycles the CPU stays in reset.
    task automatic do_start(input string tag);
        int n;
        start = 1'b1;
        step();
        start = 1'b0;
        chk({tag, ":done_clr"},   32'(done),       32'd0);
        chk({tag, ":status_clr"}, 32'(status),     32'd0);
        chk({tag, ":cycles_clr"}, run_cycles,      32'd0);
        n = 0;
        while (cpu_rst_n == 1'b0 && n < 20) begin
            chk({tag, ":hold_busy"}, 32'(busy), 32'd1);
            n++;
            step();
        end
        chk({tag, ":hold_len"},   32'(n),         32'(RESET_CYCLES));
        chk({tag, ":release"},    32'(cpu_rst_n), 32'd1);
        chk({tag, ":run_busy"},   32'(busy),      32'd1);
    endtask

    // Feed pc_vec one entry per RUN cycle until done rises, then check the end-of-run report.
    task automatic run_vec(input string tag, input int len, input int n_exp,
                           input logic [1:0] st_exp, input logic [31:0] pc_exp);
        int n;
        n = 0;
        for (int i = 0; i < len; i++) begin
            cpu_pc = pc_vec[i];
            start  = (i == start_at);
            step();
            start  = 1'b0;
            n++;
            if (done) break;
        end
        chk({tag, ":length"},     32'(n),         32'(n_exp));
        chk({tag, ":done"},       32'(done),      32'd1);
        chk({tag, ":status"},     32'(status),    32'(st_exp));
        chk({tag, ":final_pc"},   final_pc,       pc_exp);
        chk({tag, ":run_cycles"}, run_cycles,     32'(n_exp));
        chk({tag, ":busy"},       32'(busy),      32'd0);
        chk({tag, ":cpu_rst_n"},  32'(cpu_rst_n), 32'd0);
        $display("run %s: cycles=%0d status=%0d final_pc=0x%08h", tag, run_cycles, status, final_pc);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded its time budget");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // Reset values while rst is held low.
        step();
        step();
        chk("rst:cpu_rst_n",  32'(cpu_rst_n), 32'd0);
        chk("rst:busy",       32'(busy),      32'd0);
        chk("rst:done",       32'(done),      32'd0);
        chk("rst:status",     32'(status),    32'd0);
        chk("rst:final_pc",   final_pc,       32'd0);
        chk("rst:run_cycles", run_cycles,     32'd0);
        rst = 1'b1;
        step();
        chk("idle:busy",      32'(busy),      32'd0);

        // Halt: 0,4,8,8,8,8 -> third repeat of 8 on RUN cycle 6.
        do_start("halt");
        pc_vec[0] = 32'd0; pc_vec[1] = 32'd4; pc_vec[2] = 32'd8;
        pc_vec[3] = 32'd8; pc_vec[4] = 32'd8; pc_vec[5] = 32'd8; pc_vec[6] = 32'd8;
        run_vec("halt", 7, 6, 2'b01, 32'd8);

        // DONE holds its outputs while the PC keeps moving.
        cpu_pc = 32'h0000_0123;
        step();
        step();
        chk("done_hold:done",       32'(done),   32'd1);
        chk("done_hold:status",     32'(status), 32'd1);
        chk("done_hold:final_pc",   final_pc,    32'd8);
        chk("done_hold:run_cycles", run_cycles,  32'd6);

        // Misaligned PC on RUN cycle 3 (re-run from DONE).
        do_start("fault_align");
        pc_vec[0] = 32'd0; pc_vec[1] = 32'd4; pc_vec[2] = 32'd6; pc_vec[3] = 32'd8;
        run_vec("fault_align", 4, 3, 2'b11, 32'd6);
`ifdef SC_RUN_PCHIST_EN
        chk("pchist:slot0", pc_hist[31:0],   32'd6);
        chk("pchist:slot1", pc_hist[63:32],  32'd4);
        chk("pchist:slot2", pc_hist[95:64],  32'd0);
        chk("pchist:slot3", pc_hist[127:96], 32'd0);
`endif

        // PC at the memory limit is a fault.
        do_start("fault_range");
        pc_vec[0] = 32'd0; pc_vec[1] = 32'h0000_1000; pc_vec[2] = 32'd0;
        run_vec("fault_range", 3, 2, 2'b11, 32'h0000_1000);

        // Timeout after 10 RUN cycles; a start pulse mid-run must be ignored.
        do_start("timeout");
        set_ramp(12, 32'd0);
        start_at = 4;
        run_vec("timeout", 12, 10, 2'b10, 32'd36);
        start_at = -1;

        // Halt and timeout on the same cycle: halt wins.
        do_start("halt_vs_to");
        set_ramp(7, 32'd0);
        pc_vec[7] = 32'd24; pc_vec[8] = 32'd24; pc_vec[9] = 32'd24; pc_vec[10] = 32'd24;
        run_vec("halt_vs_to", 11, 10, 2'b01, 32'd24);

        // Fault and timeout on the same cycle: fault wins.
        do_start("fault_vs_to");
        set_ramp(9, 32'd0);
        pc_vec[9] = 32'h0000_1004; pc_vec[10] = 32'd0;
        run_vec("fault_vs_to", 11, 10, 2'b11, 32'h0000_1004);

        // Last valid word address is not a fault; four equal samples halt.
        do_start("edge_pc");
        for (int i = 0; i < 6; i++) pc_vec[i] = 32'h0000_0FFC;
        run_vec("edge_pc", 6, 4, 2'b01, 32'h0000_0FFC);

        // Abort mid-run: reset takes effect without a clock edge.
        do_start("abort");
        set_ramp(3, 32'h40);
        for (int i = 0; i < 3; i++) begin
            cpu_pc = pc_vec[i];
            step();
        end
        chk("abort:pre_cycles", run_cycles, 32'd3);
        #2;
        rst = 1'b0;
        #1;
        chk("abort:cpu_rst_n",  32'(cpu_rst_n), 32'd0);
        chk("abort:busy",       32'(busy),      32'd0);
        chk("abort:run_cycles", run_cycles,     32'd0);
        chk("abort:final_pc",   final_pc,       32'd0);
        step();
        rst = 1'b1;
        step();
        chk("abort:idle_busy",  32'(busy),      32'd0);
        chk("abort:idle_done",  32'(done),      32'd0);
        $display("run abort: cpu_rst_n=%0d busy=%0d", cpu_rst_n, busy);

        // Recovery run after the abort.
        do_start("recover");
        for (int i = 0; i < 6; i++) pc_vec[i] = 32'h0000_0100;
        run_vec("recover", 6, 4, 2'b01, 32'h0000_0100);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
